// File: rtl/vmem_pkg.sv
// Shared types and helpers for the video-memory read-port arbiter.
// Optional build macro used by the arbiter: VMEM_ARB_FIXED_PRIO_EN.
package vmem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } arb_state_e;

   localparam int VMEM_ADDR_W = 22;

   // Width of a requester index; never narrower than one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational pick of the first set request bit, searching upward from
// a start index and wrapping past N-1 back to 0.
module rr_pick #(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx
);

   logic [N-1:0] rot;

   // Rotating the doubled vector puts the start requester at bit 0.
   assign rot = N'({req, req} >> start);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            idx   = W'((int'(start) + k) % N);
         end
      end
   end

endmodule

// File: rtl/vmem_bus_arbiter.sv
// Shares one 16-bit video-memory read port between NUM_REQ fetch requesters.
// Round-robin by default; define VMEM_ARB_FIXED_PRIO_EN for lowest-index-wins.
module vmem_bus_arbiter
   import vmem_pkg::*;
#(
   parameter int NUM_REQ   = 3,
   parameter int MAX_BURST = 8,
   parameter int ADDR_W    = VMEM_ADDR_W
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_as,
   input  logic [NUM_REQ*ADDR_W-1:0] req_address,
   output logic [NUM_REQ-1:0]        req_ack,
   output logic [15:0]               req_din,
   output logic [ADDR_W-1:0]         mem_address,
   output logic                      mem_as,
   input  logic [15:0]               mem_din,
   input  logic                      mem_ack,
   output logic [idx_w(NUM_REQ)-1:0] grant_id,
   output logic                      grant_valid
);

   localparam int            IW         = idx_w(NUM_REQ);
   localparam logic [IW-1:0] LAST_ID    = IW'(NUM_REQ - 1);
   localparam logic [7:0]    BURST_LAST = 8'(MAX_BURST - 1);

   arb_state_e         state_q, state_d;
   logic [IW-1:0]      grant_id_q, grant_id_d;
   logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [7:0]         burst_cnt_q, burst_cnt_d;
   logic [IW-1:0]      pick_start, pick_idx, next_ptr;
   logic               pick_found, cur_as, others_wait, in_grant;
   logic [NUM_REQ-1:0] grant_oh;

`ifdef VMEM_ARB_FIXED_PRIO_EN
   assign pick_start = '0;
   assign next_ptr   = '0;
`else
   assign pick_start = rr_ptr_q;
   assign next_ptr   = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IW'(1);
`endif

   rr_pick #(
      .N (NUM_REQ),
      .W (IW)
   ) u_pick (
      .req   (req_as),
      .start (pick_start),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      grant_oh             = '0;
      grant_oh[grant_id_q] = 1'b1;
   end

   assign in_grant    = (state_q == GRANT);
   assign cur_as      = req_as[grant_id_q];
   assign others_wait = |(req_as & ~grant_oh);

   always_comb begin
      // NOTE: every _d starts from its _q, so no path through the case leaves a latch behind.
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      rr_ptr_d    = rr_ptr_q;
      burst_cnt_d = burst_cnt_q;
      unique case (state_q)
         IDLE, GAP: begin
            if (pick_found) begin
               state_d     = GRANT;
               grant_id_d  = pick_idx;
               burst_cnt_d = '0;
            end else begin
               state_d = IDLE;
            end
         end
         GRANT: begin
            if (!cur_as) begin
               state_d  = IDLE;
               rr_ptr_d = next_ptr;
            end else if (mem_ack) begin
               // Counter parks at the cap so a late arrival preempts on the next word.
               if (burst_cnt_q == BURST_LAST && others_wait) begin
                  state_d  = GAP;
                  rr_ptr_d = next_ptr;
               end else if (burst_cnt_q != BURST_LAST) begin
                  burst_cnt_d = burst_cnt_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         grant_id_q  <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   // Address and strobe follow the granted requester combinationally so it can
   // present its next burst address in the cycle after an ack.
   assign mem_as      = in_grant & cur_as;
   assign mem_address = in_grant ? req_address[int'(grant_id_q)*ADDR_W +: ADDR_W] : '0;
   assign req_ack     = (in_grant && mem_ack) ? grant_oh : '0;
   assign req_din     = mem_din;
   assign grant_id    = grant_id_q;
   assign grant_valid = in_grant;

endmodule

// File: tb/tb_vmem_bus_arbiter.sv
// Scoreboard bench for vmem_bus_arbiter: requester and memory models, expected
// read data and grant order queued at stimulus time and popped on DUT events.
`timescale 1ns/1ps
module tb_vmem_bus_arbiter;

   localparam int NUM_REQ = 3;
   localparam int ADDR_W  = 22;
`ifdef VMEM_ARB_FIXED_PRIO_EN
   localparam int MB = 2;
`else
   localparam int MB = 4;
`endif

   logic                      clk = 1'b0;
   logic                      reset_n;
   logic [NUM_REQ-1:0]        req_as;
   logic [NUM_REQ*ADDR_W-1:0] req_address;
   logic [NUM_REQ-1:0]        req_ack;
   logic [15:0]               req_din;
   logic [ADDR_W-1:0]         mem_address;
   logic                      mem_as;
   logic [15:0]               mem_din;
   logic                      mem_ack;
   logic [1:0]                grant_id;
   logic                      grant_valid;

   typedef struct {
      int          id;
      logic [15:0] data;
   } exp_t;

   exp_t              sb[$];
   int                grant_q[$];
   int                checks = 0;
   int                errors = 0;
   int                words_left[NUM_REQ];
   logic [ADDR_W-1:0] cur_addr[NUM_REQ];
   int                ack_cnt[NUM_REQ];
   int                mem_lat = 1;
   int                mem_cnt = 0;
   int                grant_starts = 0;
   int                cur_owner = -1;
   logic              prev_valid = 1'b0;

   always #5 clk = ~clk;

   vmem_bus_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .MAX_BURST (MB),
      .ADDR_W    (ADDR_W)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_as      (req_as),
      .req_address (req_address),
      .req_ack     (req_ack),
      .req_din     (req_din),
      .mem_address (mem_address),
      .mem_as      (mem_as),
      .mem_din     (mem_din),
      .mem_ack     (mem_ack),
      .grant_id    (grant_id),
      .grant_valid (grant_valid)
   );

   function automatic logic [15:0] mem_data(input logic [ADDR_W-1:0] a);
      return a[15:0] ^ 16'h5EBC;
   endfunction

   function automatic bit all_done();
      bit d;
      d = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) if (words_left[i] > 0) d = 1'b0;
      return d;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic start_burst(input int id, input logic [ADDR_W-1:0] addr, input int n);
      exp_t e;
      words_left[id] = n;
      cur_addr[id]   = addr;
      ack_cnt[id]    = 0;
      for (int k = 0; k < n; k++) begin
         e.id   = id;
         e.data = mem_data(addr + ADDR_W'(2 * k));
         sb.push_back(e);
      end
   endtask

   task automatic handle_ack();
      int id;
      int hit;
      id = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) if (req_ack[i]) id = i;
      check("ack_onehot", 32'($onehot(req_ack)), 1);
      check("ack_owner", id, cur_owner);
      check("ack_addr", mem_address, cur_addr[id]);
      hit = -1;
      for (int k = 0; k < sb.size(); k++) if (hit < 0 && sb[k].id == id) hit = k;
      check("sb_hit", 32'(hit >= 0), 1);
      if (hit >= 0) begin
         check("ack_data", req_din, sb[hit].data);
         sb.delete(hit);
      end
      ack_cnt[id]++;
      if (words_left[id] > 0) begin
         words_left[id]--;
         cur_addr[id] = cur_addr[id] + ADDR_W'(2);
      end
   endtask

   // One clock: requesters drive, memory model answers, monitor samples.
   task automatic cycle();
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
         req_as[i]                       = (words_left[i] > 0);
         req_address[i*ADDR_W +: ADDR_W] = cur_addr[i];
      end
      #1;
      mem_ack = 1'b0;
      if (mem_as) begin
         mem_cnt++;
         if (mem_cnt >= mem_lat) begin
            mem_ack = 1'b1;
            mem_din = mem_data(mem_address);
            mem_cnt = 0;
         end
      end else begin
         mem_cnt = 0;
      end
      #1;
      if (grant_valid && !prev_valid) begin
         grant_starts++;
         check("grant_pending", 32'(grant_q.size() > 0), 1);
         if (grant_q.size() > 0) begin
            cur_owner = grant_q.pop_front();
            check("grant_id", grant_id, cur_owner);
         end else begin
            cur_owner = -1;
         end
      end
      prev_valid = grant_valid;
      if (req_ack != '0) handle_ack();
   endtask

   task automatic run_until_idle(input string tag, input int max_cyc);
      int n;
      n = 0;
      while (n < max_cyc && !(all_done() && !grant_valid)) begin
         cycle();
         n++;
      end
      check({tag, "_done"}, 32'(all_done() && !grant_valid), 1);
      check({tag, "_sb_empty"}, sb.size(), 0);
      check({tag, "_grants_used"}, grant_q.size(), 0);
   endtask

   task automatic wait_acks(input string tag, input int id, input int n, input int max_cyc);
      int c;
      c = 0;
      while (ack_cnt[id] < n && c < max_cyc) begin
         cycle();
         c++;
      end
      check({tag, "_acks"}, ack_cnt[id], n);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach the summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n     = 1'b0;
      req_as      = '0;
      req_address = '0;
      mem_din     = '0;
      mem_ack     = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         words_left[i] = 0;
         cur_addr[i]   = '0;
         ack_cnt[i]    = 0;
      end
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", grant_valid, 0);
      check("rst_gid", grant_id, 0);
      check("rst_mem_as", mem_as, 0);
      check("rst_mem_addr", mem_address, 0);
      check("rst_ack", req_ack, 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Two requesters together from pointer 0: 0 bursts first, then 2.
      mem_lat = 1;
      start_burst(0, 22'h400, 2);
      start_burst(2, 22'h800, 2);
      grant_q.push_back(0);
      grant_q.push_back(2);
      run_until_idle("t2", 40);

      // Single requester, memory answers on the second strobe cycle.
      mem_lat = 2;
      start_burst(1, 22'h400, 1);
      grant_q.push_back(1);
      cycle();
      check("t1_as_lat0", mem_as, 0);
      cycle();
      check("t1_as_lat1", mem_as, 1);
      check("t1_addr", mem_address, 22'h400);
      check("t1_no_ack_yet", req_ack, 0);
      cycle();
      check("t1_ack", req_ack, 3'b010);
      check("t1_din", req_din, 16'h5ABC);
      run_until_idle("t1", 20);

      // A memory ack while idle must not reach any requester.
      @(negedge clk);
      mem_ack = 1'b1;
      #1;
      check("idle_stray_ack", req_ack, 0);
      @(posedge clk);
      #1;
      check("idle_stray_valid", grant_valid, 0);
      mem_ack = 1'b0;

`ifndef VMEM_ARB_FIXED_PRIO_EN
      // Requester 0 streams while 1 waits: capped burst, one gap, then 1.
      mem_lat = 1;
      start_burst(0, 22'h1000, 6);
      start_burst(1, 22'h2000, 2);
      grant_q.push_back(0);
      grant_q.push_back(1);
      grant_q.push_back(0);
      wait_acks("t3_burst", 0, MB, 40);
      cycle();
      check("t3_gap_as", mem_as, 0);
      check("t3_gap_valid", grant_valid, 0);
      mem_ack = 1'b1;
      #1;
      check("t3_gap_ack", req_ack, 0);
      mem_ack = 1'b0;
      cycle();
      check("t3_regrant_valid", grant_valid, 1);
      check("t3_regrant_id", grant_id, 1);
      run_until_idle("t3", 60);
`else
      // Fixed priority: 1 regains the grant after each gap, 2 waits for it to drop.
      mem_lat = 1;
      start_burst(1, 22'h500, 6);
      start_burst(2, 22'h600, 2);
      grant_q.push_back(1);
      grant_q.push_back(1);
      grant_q.push_back(1);
      grant_q.push_back(2);
      run_until_idle("t6", 80);
`endif

      // Lone requester is never capped.
      mem_lat      = 1;
      grant_starts = 0;
      start_burst(0, 22'h3000, 10);
      grant_q.push_back(0);
      run_until_idle("t4", 60);
      check("t4_single_grant", grant_starts, 1);
      check("t4_words", ack_cnt[0], 10);

      // Reset mid-burst, then arbitration restarts from pointer 0.
      mem_lat = 2;
      start_burst(2, 22'h3800, 4);
      grant_q.push_back(2);
      wait_acks("t5_first", 2, 1, 20);
      reset_n = 1'b0;
      mem_ack = 1'b1;
      #1;
      check("t5_rst_as", mem_as, 0);
      check("t5_rst_valid", grant_valid, 0);
      check("t5_rst_ack", req_ack, 0);
      check("t5_rst_addr", mem_address, 0);
      check("t5_rst_gid", grant_id, 0);
      mem_ack       = 1'b0;
      words_left[2] = 0;
      req_as        = '0;
      mem_cnt       = 0;
      prev_valid    = 1'b0;
      for (int k = sb.size() - 1; k >= 0; k--) if (sb[k].id == 2) sb.delete(k);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      mem_lat = 1;
      start_burst(0, 22'h100, 2);
      start_burst(2, 22'h200, 2);
      grant_q.push_back(0);
      grant_q.push_back(2);
      run_until_idle("t5", 40);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vmem_bus_arbiter.md
Name: vmem_bus_arbiter

Overview:
- Shares one 16-bit video-memory read port between N fetch requesters: odd/even ICA/DCA sequencers and the pixel fetch unit.
- Each requester uses the same address/as/bus_ack handshake the display sequencers already speak, and holds as high across multi-word bursts (e.g. 32-bit instruction = 2 words).
- The arbiter grants one requester at a time, forwards its address to the memory port, and routes the returned data and ack back.
- Round-robin by default; bursts are capped so no requester can starve the others.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MAX_BURST, 8, max words per grant before forced re-arbitration when others wait (1..255)
ADDR_W, 22, word-address width

Ports:
clk  in  1  system clock
reset_n  in  1  reset, active-low; asserts asynchronously, deasserts synchronously
req_as  in  NUM_REQ  per-requester address strobe; held high until ack, may stay high for bursts
req_address  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies slice [i*ADDR_W +: ADDR_W]
req_ack  out  NUM_REQ  per-requester one-cycle data-valid ack
req_din  out  16  read data broadcast to all requesters
mem_address  out  ADDR_W  address to memory controller
mem_as  out  1  strobe to memory controller
mem_din  in  16  read data from memory controller
mem_ack  in  1  one-cycle ack from memory controller; mem_din valid that cycle
grant_id  out  $clog2(NUM_REQ)  currently or last granted requester
grant_valid  out  1  a grant is active

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values: state=IDLE, grant_id=0, grant_valid=0, rr pointer=0, burst_cnt=0. Outputs mem_as=0, req_ack=0, mem_address=0.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If any req_as is high, pick the winner: the first requester with req_as high, searching from rr_ptr upward with wrap.
  - Register grant_id, set burst_cnt=0, go to GRANT.
  - Latency from req_as rising to mem_as rising is 1 cycle.
- GRANT:
  - mem_as = req_as[grant_id]. mem_address = req_address[grant_id] (combinational; the requester may update its address in the same cycle it receives an ack).
  - req_ack[grant_id] = mem_ack. All other acks are 0.
  - req_din = mem_din at all times.
  - On mem_ack: burst_cnt++.
- Leaving GRANT:
  - Requester drops req_as: go to IDLE next cycle and set rr_ptr = grant_id+1 (mod NUM_REQ). A drop with no ack (abort) is legal and behaves the same.
  - mem_ack while burst_cnt==MAX_BURST-1, another requester's req_as is high, and the current requester still holds as: go to GAP and set rr_ptr = grant_id+1.
  - If no other requester is waiting, the burst continues without limit; burst_cnt saturates.
- GAP:
  - mem_as=0 for exactly 1 cycle, then arbitrate as in IDLE. The preempted requester keeps as high and competes normally.
- Boundaries:
  - mem_ack outside GRANT is ignored; no req_ack is produced.
  - A requester asserting as in the same cycle another releases is seen in IDLE the next cycle.
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - reset_n low mid-burst: mem_as drops immediately (asynchronously); the granted requester gets no ack.
- grant_valid = (state==GRANT).

Optional Feature:
- Macro: VMEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; lowest index wins; rr_ptr is unused and held at 0. MAX_BURST preemption still applies, but a preempted requester regains the grant after GAP if it has the lowest index waiting.
- Undefined: round-robin as above.

Decomposition:
- Shared package vmem_pkg: state enum typedef (IDLE/GRANT/GAP), ADDR_W default constant, grant-index width function.
- One natural sub-module, rr_pick: combinational pick of the first set bit from a start pointer with wrap. Under the macro, the start pointer is tied to 0.

Test Plan:
1. Single requester 1 asserts as with address 0x400, memory acks after 2 cycles. Required: mem_as high at cycle 1, mem_address 0x400, req_ack[1] with req_din=0x5ABC, grant released after as drops.
2. Requesters 0 and 2 assert together with rr_ptr=0. Required: 0 granted for a 2-word burst (0x400, 0x402), then IDLE, then 2 granted.
3. MAX_BURST=4; requester 0 streams continuously while requester 1 waits. Required: after the 4th ack, one GAP cycle with mem_as=0, then grant_id=1.
4. Same as 3 but no other requester waiting. Required: requester 0 keeps the grant for 10 words with no gap.
5. Reset_n pulled low mid-burst. Required: mem_as=0 in the same cycle, grant_valid=0, no req_ack; after release, normal arbitration from rr_ptr=0.
6. With VMEM_ARB_FIXED_PRIO_EN defined, requesters 1 and 2 stream continuously with MAX_BURST=2. Required: 1 regains the grant after every GAP; 2 is granted only when 1 drops as.
